fetch_stage: RTL and testbench

//  Instruction-fetch stage directly upstream of the F/D pipeline register. Owns the PC, issues

---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/fetch_stage_if.sv | 31 +++
 rtl/fetch_stage_btb.sv | 67 ++++++
 rtl/fetch_stage.sv | 132 +++++++++++++
 tb/tb_fetch_stage.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants, FSM state type and BTB counter helper for the fetch stage.
package fetch_stage_pkg;

    localparam int unsigned DEFAULT_PC_WIDTH    = 32;
    localparam int unsigned DEFAULT_INSTR_WIDTH = 32;
    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h8000_0000;
    localparam logic [31:0] NOP_INSTR           = 32'h0000_0013;
    localparam logic [6:0]  OPC_JAL             = 7'b1101111;
    localparam logic [1:0]  CTR_ALLOC           = 2'b10;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } fetch_state_e;

    // Two-bit saturating direction counter.
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between fetch and the memory.
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = DEFAULT_PC_WIDTH,
    parameter int unsigned INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) ();

    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_resp_valid;
    logic [INSTR_WIDTH-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );

endinterface

// File: rtl/fetch_stage_btb.sv
// Direct-mapped branch target buffer: combinational lookup, registered update.
module fetch_btb
    import fetch_stage_pkg::*;
#(
    parameter int unsigned PC_WIDTH = DEFAULT_PC_WIDTH,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                clk_i,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] lkp_pc_i,
    output logic                lkp_hit_o,
    output logic                lkp_taken_o,
    output logic [PC_WIDTH-1:0] lkp_target_o,
    input  logic                upd_valid_i,
    input  logic [PC_WIDTH-1:0] upd_pc_i,
    input  logic [PC_WIDTH-1:0] upd_target_i,
    input  logic                upd_taken_i
);

    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam int unsigned TAG_W   = PC_WIDTH - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q [ENTRIES];
    logic [PC_WIDTH-1:0] tgt_q [ENTRIES];
    logic [1:0]          ctr_q [ENTRIES];

    logic [IDX_W-1:0] lkp_idx, upd_idx;
    logic [TAG_W-1:0] lkp_tag, upd_tag;
    logic             upd_hit;
    logic             unused_pc_lsb;

    assign lkp_idx = lkp_pc_i[IDX_W+1:2];
    assign lkp_tag = lkp_pc_i[PC_WIDTH-1:IDX_W+2];
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[PC_WIDTH-1:IDX_W+2];
    assign unused_pc_lsb = ^{lkp_pc_i[1:0], upd_pc_i[1:0]};

    // Reads see the registered arrays, so a same-cycle update is not visible yet.
    assign lkp_hit_o    = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    assign lkp_taken_o  = lkp_hit_o && ctr_q[lkp_idx][1];
    assign lkp_target_o = tgt_q[lkp_idx];

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_ff @(posedge clk_i) begin
        if (rst) begin
            valid_q <= '0;
        end else if (upd_valid_i && !upd_hit && upd_taken_i) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (upd_valid_i) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= ctr_update(ctr_q[upd_idx], upd_taken_i);
                if (upd_taken_i) tgt_q[upd_idx] <= upd_target_i;
            end else if (upd_taken_i) begin
                tag_q[upd_idx] <= upd_tag;
                tgt_q[upd_idx] <= upd_target_i;
                ctr_q[upd_idx] <= CTR_ALLOC;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, one outstanding memory request, BTB-predicted nPC,
// and a single-entry instruction buffer presented to the F/D register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned         PC_WIDTH    = DEFAULT_PC_WIDTH,
    parameter int unsigned         INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned         BTB_IDX_W   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst,
    input  logic                   redirect_valid_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    input  logic                   decode_allow_in_i,
    fetch_stage_if.master          imem,
    input  logic                   btb_upd_valid_i,
    input  logic [PC_WIDTH-1:0]    btb_upd_pc_i,
    input  logic [PC_WIDTH-1:0]    btb_upd_target_i,
    input  logic                   btb_upd_taken_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [PC_WIDTH-1:0]    F_PC_o,
    output logic [PC_WIDTH-1:0]    F_nPC_o,
    output logic                   F_commit_o,
    output logic                   F_train_predict_o,
    output logic                   F_success_hit_o,
    output logic                   F_jal_o,
    output logic                   fetch_ready_o
);

    localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(NOP_INSTR);

    fetch_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    cap_pc_q, npc_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic                   hit_q, pred_q;
    logic                   capture;
    logic                   btb_hit, btb_taken;
    logic [PC_WIDTH-1:0]    btb_target;
    logic                   in_hold;

    fetch_btb #(
        .PC_WIDTH (PC_WIDTH),
        .IDX_W    (BTB_IDX_W)
    ) u_btb (
        .clk_i        (clk_i),
        .rst          (rst),
        .lkp_pc_i     (pc_q),
        .lkp_hit_o    (btb_hit),
        .lkp_taken_o  (btb_taken),
        .lkp_target_o (btb_target),
        .upd_valid_i  (btb_upd_valid_i),
        .upd_pc_i     (btb_upd_pc_i),
        .upd_target_i (btb_upd_target_i),
        .upd_taken_i  (btb_upd_taken_i)
    );

    assign imem.imem_req_valid = (state_q == S_REQ);
    assign imem.imem_addr      = pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;
        case (state_q)
            S_REQ: begin
                if (redirect_valid_i) pc_d = redirect_pc_i;
                // A request accepted alongside a redirect is already stale.
                if (imem.imem_req_ready) state_d = redirect_valid_i ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = imem.imem_resp_valid ? S_REQ : S_DROP;
                end else if (imem.imem_resp_valid) begin
                    capture = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = S_REQ;
                end else if (decode_allow_in_i) begin
                    pc_d    = npc_q;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect_valid_i) pc_d = redirect_pc_i;
                if (imem.imem_resp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            instr_q  <= NOP;
            cap_pc_q <= '0;
            npc_q    <= '0;
            hit_q    <= 1'b0;
            pred_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (capture) begin
                instr_q  <= imem.imem_resp_data;
                cap_pc_q <= pc_q;
                npc_q    <= btb_taken ? btb_target : pc_q + PC_WIDTH'(4);
                hit_q    <= btb_hit;
                pred_q   <= btb_taken;
            end
        end
    end

    always_comb begin
        in_hold           = (state_q == S_HOLD);
        fetch_ready_o     = in_hold && !redirect_valid_i;
        F_commit_o        = fetch_ready_o;
        instr_o           = in_hold ? instr_q : NOP;
        F_jal_o           = in_hold && (instr_q[6:0] == OPC_JAL);
        F_train_predict_o = in_hold && pred_q;
        F_success_hit_o   = in_hold && hit_q;
        F_PC_o            = cap_pc_q;
        F_nPC_o           = npc_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a transaction-level PC/BTB model and a latency-programmable memory.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] JAL_PC = 32'h8000_0200;

    logic        clk_i = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        decode_allow_in_i = 1'b0;
    logic        btb_upd_valid_i = 1'b0;
    logic [31:0] btb_upd_pc_i = '0;
    logic [31:0] btb_upd_target_i = '0;
    logic        btb_upd_taken_i = 1'b0;
    logic [31:0] instr_o, F_PC_o, F_nPC_o;
    logic        F_commit_o, F_train_predict_o, F_success_hit_o, F_jal_o, fetch_ready_o;

    fetch_stage_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) mif ();

    fetch_stage #(
        .PC_WIDTH    (32),
        .INSTR_WIDTH (32),
        .RESET_PC    (RST_PC),
        .BTB_IDX_W   (4)
    ) dut (
        .clk_i             (clk_i),
        .rst               (rst),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_pc_i     (redirect_pc_i),
        .decode_allow_in_i (decode_allow_in_i),
        .imem              (mif),
        .btb_upd_valid_i   (btb_upd_valid_i),
        .btb_upd_pc_i      (btb_upd_pc_i),
        .btb_upd_target_i  (btb_upd_target_i),
        .btb_upd_taken_i   (btb_upd_taken_i),
        .instr_o           (instr_o),
        .F_PC_o            (F_PC_o),
        .F_nPC_o           (F_nPC_o),
        .F_commit_o        (F_commit_o),
        .F_train_predict_o (F_train_predict_o),
        .F_success_hit_o   (F_success_hit_o),
        .F_jal_o           (F_jal_o),
        .fetch_ready_o     (fetch_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int n_fire  = 0;
    int lat     = 1;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory image: address-derived words, one jal at JAL_PC.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == JAL_PC) ? 32'h6F00_006F : {a[24:0], 7'h13};
    endfunction

    // Memory: responds exactly once, lat cycles after each accepted request.
    bit          m_pend = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_addr = '0;
    bit          m_nxt;
    initial begin
        mif.imem_req_ready  = 1'b0;
        mif.imem_resp_valid = 1'b0;
        mif.imem_resp_data  = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk_i);
            m_nxt = 1'b0;
            if (rst) m_pend = 1'b0;
            else begin
                if (mif.imem_resp_valid) m_pend = 1'b0;
                if (mif.imem_req_valid && mif.imem_req_ready) begin
                    chk("one_outstanding", {31'b0, m_pend}, 32'd0);
                    m_pend = 1'b1;
                    m_cnt  = lat;
                    m_addr = mif.imem_addr;
                end
                if (m_pend) begin
                    if (m_cnt == 1) m_nxt = 1'b1;
                    else m_cnt--;
                end
            end
            @(posedge clk_i); #1;
            mif.imem_resp_valid = m_nxt;
            mif.imem_resp_data  = m_nxt ? mem_word(m_addr) : 32'hDEAD_BEEF;
        end
    end

    // Reference model: expected fetch PC stream plus BTB contents keyed by index.
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] snap_npc = '0;
    bit          snap_hit = 1'b0, snap_pred = 1'b0;
    bit          b_v   [16];
    logic [31:0] b_pc  [16];
    logic [31:0] b_tgt [16];
    int          b_ctr [16];

    function automatic int bidx(input logic [31:0] a);
        return int'((a >> 2) & 32'hF);
    endfunction

    function automatic bit bhit(input logic [31:0] a);
        return b_v[bidx(a)] && ((b_pc[bidx(a)] >> 6) == (a >> 6));
    endfunction

    initial begin
        logic [31:0] w;
        int i;
        forever begin
            @(negedge clk_i);
            if (rst) begin
                exp_pc = RST_PC;
                for (int k = 0; k < 16; k++) b_v[k] = 1'b0;
            end else begin
                if (mif.imem_req_valid && mif.imem_req_ready) begin
                    n_fire++;
                    chk("req_addr", mif.imem_addr, exp_pc);
                end
                if (fetch_ready_o) begin
                    w = mem_word(exp_pc);
                    chk("ready_no_req", {31'b0, mif.imem_req_valid}, 32'd0);
                    chk("F_PC", F_PC_o, exp_pc);
                    chk("instr", instr_o, w);
                    chk("F_nPC", F_nPC_o, snap_npc);
                    chk("hit", {31'b0, F_success_hit_o}, {31'b0, snap_hit});
                    chk("predict", {31'b0, F_train_predict_o}, {31'b0, snap_pred});
                    chk("jal", {31'b0, F_jal_o}, {31'b0, (w[6:0] == OPC_JAL)});
                    chk("commit", {31'b0, F_commit_o}, 32'd1);
                end else if (redirect_valid_i) begin
                    chk("redirect_commit", {31'b0, F_commit_o}, 32'd0);
                end else begin
                    chk("idle_instr", instr_o, NOP_INSTR);
                    chk("idle_flags", {28'b0, F_commit_o, F_jal_o, F_train_predict_o, F_success_hit_o}, 32'd0);
                end
                // Prediction is taken from the BTB as it stands when the response arrives.
                if (mif.imem_resp_valid) begin
                    i         = bidx(exp_pc);
                    snap_hit  = bhit(exp_pc);
                    snap_pred = snap_hit && (b_ctr[i] >= 2);
                    snap_npc  = snap_pred ? b_tgt[i] : exp_pc + 32'd4;
                end
                if (redirect_valid_i) exp_pc = redirect_pc_i;
                else if (fetch_ready_o && decode_allow_in_i) exp_pc = snap_npc;
                if (btb_upd_valid_i) begin
                    i = bidx(btb_upd_pc_i);
                    if (bhit(btb_upd_pc_i)) begin
                        if (btb_upd_taken_i) begin
                            b_ctr[i] = (b_ctr[i] < 3) ? b_ctr[i] + 1 : 3;
                            b_tgt[i] = btb_upd_target_i;
                        end else begin
                            b_ctr[i] = (b_ctr[i] > 0) ? b_ctr[i] - 1 : 0;
                        end
                    end else if (btb_upd_taken_i) begin
                        b_v[i] = 1'b1; b_pc[i] = btb_upd_pc_i; b_tgt[i] = btb_upd_target_i; b_ctr[i] = 2;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i); #1;
    endtask

    task automatic wait_ready(input int max, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < max && !seen; k++) begin
            @(negedge clk_i);
            if (fetch_ready_o) seen = 1'b1;
        end
        chk(name, {31'b0, seen}, 32'd1);
    endtask

    task automatic wait_fire(input int max, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < max && !seen; k++) begin
            @(negedge clk_i);
            if (mif.imem_req_valid && mif.imem_req_ready) seen = 1'b1;
        end
        chk(name, {31'b0, seen}, 32'd1);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        step(); redirect_valid_i = 1'b1; redirect_pc_i = pc;
        step(); redirect_valid_i = 1'b0;
    endtask

    initial begin
        int t0, t1, f0;
        // Reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ready", {31'b0, fetch_ready_o}, 32'd0);
        chk("rst_instr", instr_o, 32'h0000_0013);
        chk("rst_F_PC", F_PC_o, 32'd0);
        chk("rst_F_nPC", F_nPC_o, 32'd0);
        chk("rst_flags", {28'b0, F_commit_o, F_jal_o, F_train_predict_o, F_success_hit_o}, 32'd0);
        chk("rst_addr", mif.imem_addr, 32'h8000_0000);
        chk("rst_req_valid", {31'b0, mif.imem_req_valid}, 32'd1);

        // 1: zero-wait memory, back-to-back accepts
        step(); rst = 1'b0; lat = 1; mif.imem_req_ready = 1'b1; decode_allow_in_i = 1'b1;
        wait_ready(10, "t1_timeout0"); t0 = cyc;
        chk("t1_pc0", F_PC_o, 32'h8000_0000);
        chk("t1_npc0", F_nPC_o, 32'h8000_0004);
        chk("t1_instr0", instr_o, 32'h0000_0013);
        wait_ready(10, "t1_timeout1"); t1 = cyc;
        chk("t1_pc1", F_PC_o, 32'h8000_0004);
        chk("t1_gap1", t1 - t0, 32'd3);
        wait_ready(10, "t1_timeout2"); t0 = cyc;
        chk("t1_pc2", F_PC_o, 32'h8000_0008);
        chk("t1_gap2", t0 - t1, 32'd3);

        // 2: slow memory, decode stalls in HOLD
        step(); lat = 5; decode_allow_in_i = 1'b0; f0 = n_fire;
        wait_ready(20, "t2_timeout");
        chk("t2_pc", F_PC_o, 32'h8000_000C);
        chk("t2_single_req", n_fire - f0, 32'd1);
        repeat (2) begin
            @(negedge clk_i);
            chk("t2_hold_ready", {31'b0, fetch_ready_o}, 32'd1);
            chk("t2_hold_pc", F_PC_o, 32'h8000_000C);
            chk("t2_hold_instr", instr_o, 32'h0000_0613);
        end

        // 3: redirect while waiting, late response discarded
        step(); decode_allow_in_i = 1'b1;
        step(); decode_allow_in_i = 1'b0; lat = 3;
        wait_fire(10, "t3_fire_timeout");
        redirect_to(32'h8000_0100);
        decode_allow_in_i = 1'b1;
        wait_ready(20, "t3_timeout");
        chk("t3_pc", F_PC_o, 32'h8000_0100);
        chk("t3_instr", instr_o, 32'h0000_8013);

        // 4: one taken update allocates a predicting entry
        step(); decode_allow_in_i = 1'b0; lat = 1;
        btb_upd_valid_i = 1'b1; btb_upd_pc_i = 32'h8000_0008;
        btb_upd_target_i = 32'h8000_0040; btb_upd_taken_i = 1'b1;
        step(); btb_upd_valid_i = 1'b0;
        redirect_to(32'h8000_0008);
        wait_ready(20, "t4_timeout");
        chk("t4_pc", F_PC_o, 32'h8000_0008);
        chk("t4_hit", {31'b0, F_success_hit_o}, 32'd1);
        chk("t4_pred", {31'b0, F_train_predict_o}, 32'd1);
        chk("t4_npc", F_nPC_o, 32'h8000_0040);
        step(); decode_allow_in_i = 1'b1;
        step(); decode_allow_in_i = 1'b0;
        wait_ready(20, "t4_follow_timeout");
        chk("t4_follow_pc", F_PC_o, 32'h8000_0040);

        // 5: three not-taken updates saturate the counter low
        step(); btb_upd_valid_i = 1'b1; btb_upd_taken_i = 1'b0;
        step(); step();
        step(); btb_upd_valid_i = 1'b0;
        redirect_to(32'h8000_0008);
        wait_ready(20, "t5_timeout");
        chk("t5_hit", {31'b0, F_success_hit_o}, 32'd1);
        chk("t5_pred", {31'b0, F_train_predict_o}, 32'd0);
        chk("t5_npc", F_nPC_o, 32'h8000_000C);

        // 6: jal flag, redirect during HOLD suppresses fetch_ready
        redirect_to(JAL_PC);
        wait_ready(20, "t6_timeout");
        chk("t6_jal", {31'b0, F_jal_o}, 32'd1);
        chk("t6_instr", instr_o, 32'h6F00_006F);
        step(); redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0300;
        @(negedge clk_i);
        chk("t6_redirect_ready", {31'b0, fetch_ready_o}, 32'd0);
        step(); redirect_valid_i = 1'b0;
        wait_ready(20, "t6_after_timeout");
        chk("t6_after_pc", F_PC_o, 32'h8000_0300);
        chk("t6_after_jal", {31'b0, F_jal_o}, 32'd0);

        // 7: PC wraps silently at the top of the address space
        redirect_to(32'hFFFF_FFFC);
        wait_ready(20, "t7_timeout");
        chk("t7_npc_wrap", F_nPC_o, 32'h0000_0000);
        step(); decode_allow_in_i = 1'b1;
        step(); decode_allow_in_i = 1'b0;
        wait_fire(10, "t7_fire_timeout");
        chk("t7_wrap_addr", mif.imem_addr, 32'h0000_0000);

        // 8: reset mid-request restarts at RESET_PC and clears the BTB
        step(); lat = 3;
        wait_ready(20, "t8_pre_timeout");
        step(); decode_allow_in_i = 1'b1;
        step(); decode_allow_in_i = 1'b0;
        wait_fire(10, "t8_fire_timeout");
        step(); rst = 1'b1;
        step();
        @(negedge clk_i);
        chk("t8_rst_addr", mif.imem_addr, 32'h8000_0000);
        chk("t8_rst_ready", {31'b0, fetch_ready_o}, 32'd0);
        step(); rst = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0008;
        step(); redirect_valid_i = 1'b0;
        wait_ready(30, "t8_timeout");
        chk("t8_pc", F_PC_o, 32'h8000_0008);
        chk("t8_btb_cleared", {31'b0, F_success_hit_o}, 32'd0);
        chk("t8_npc", F_nPC_o, 32'h8000_000C);

        repeat (2) @(posedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
